// File: rtl/task_dispatcher.sv
// Task dispatcher: loads a task program through a write port and broadcasts control and
// instruction frames to the core array under NO/ACQ/REL fences. Optional macro TS_WRAP_EN: ring-mode task memory.
module task_dispatcher #(
  parameter int NUM_CORES = 4,
  parameter int TM_DEPTH  = 64,
  parameter int REG_W     = 8,
  parameter int IF_NUM_W  = 4,
  parameter int FRAME_W   = 64
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        tm_we,
  input  logic [$clog2(TM_DEPTH)-1:0] tm_waddr,
  input  logic [FRAME_W-1:0]          tm_wdata,
  input  logic                        run,
  input  logic [NUM_CORES-1:0]        ready,
  output logic [NUM_CORES-1:0]        start,
  output logic [FRAME_W-1:0]          insn_data,
  output logic [NUM_CORES-1:0]        init_r0_vect,
  output logic [NUM_CORES*REG_W-1:0]  init_r0,
  output logic                        busy,
  output logic                        done,
  output logic                        err
);
  localparam int PTR_W   = $clog2(TM_DEPTH);
  localparam int ACT_LSB = 2;
  localparam int N_LSB   = ACT_LSB + NUM_CORES;
  localparam int R0V_LSB = N_LSB + IF_NUM_W;
  localparam int R0_LSB  = R0V_LSB + NUM_CORES;
  localparam int CTRL_W  = R0_LSB + NUM_CORES * REG_W;
  localparam logic [1:0] FENCE_ACQ = 2'b01;
  localparam logic [1:0] FENCE_REL = 2'b10;
  localparam logic [1:0] FENCE_END = 2'b11;

  if (FRAME_W < CTRL_W) begin : g_frame_w_check
    $error("task_dispatcher: FRAME_W too narrow for the control frame layout");
  end
  if (NUM_CORES < 1 || NUM_CORES > 16) begin : g_cores_check
    $error("task_dispatcher: NUM_CORES must be within 1..16");
  end

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_EVAL  = 3'd2,
    ST_ISSUE = 3'd3,
    ST_GUARD = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  logic [FRAME_W-1:0]         mem_r [TM_DEPTH];
  state_t                     state_r, state_s;
  logic [PTR_W-1:0]           ptr_r, ptr_s;
  logic [CTRL_W-1:0]          ctrl_r, ctrl_s;
  logic [IF_NUM_W-1:0]        rem_r, rem_s;
  logic                       pend_r, pend_s;
  logic                       ovf_r, ovf_s;
  logic [NUM_CORES-1:0]       start_r, start_s;
  logic [FRAME_W-1:0]         insn_r, insn_s;
  logic [NUM_CORES-1:0]       vect_r, vect_s;
  logic [NUM_CORES*REG_W-1:0] r0_r, r0_s;
  logic                       busy_r, busy_s;
  logic                       done_r, done_s;
  logic                       err_r, err_s;
  logic [FRAME_W-1:0]         rd_s;
  logic                       at_end_s;

  logic [1:0]                 fence_s;
  logic [NUM_CORES-1:0]       act_s;
  logic [IF_NUM_W-1:0]        n_s;
  logic [NUM_CORES-1:0]       r0v_s;
  logic [NUM_CORES*REG_W-1:0] r0val_s;

  assign fence_s = ctrl_r[1:0];
  assign act_s   = ctrl_r[ACT_LSB +: NUM_CORES];
  assign n_s     = ctrl_r[N_LSB +: IF_NUM_W];
  assign r0v_s   = ctrl_r[R0V_LSB +: NUM_CORES];
  assign r0val_s = ctrl_r[R0_LSB +: NUM_CORES * REG_W];

  // Write-first read: a same-cycle write to the read address is forwarded.
  assign rd_s = (tm_we && !busy_r && (tm_waddr == ptr_r)) ? tm_wdata : mem_r[ptr_r];

`ifdef TS_WRAP_EN
  assign at_end_s = 1'b0;
`else
  assign at_end_s = (ptr_r == PTR_W'(TM_DEPTH - 1));
`endif

  // Task memory write port; contents survive reset and are frozen while busy
  always_ff @(posedge clk) begin
    if (tm_we && !busy_r) begin
      mem_r[tm_waddr] <= tm_wdata;
    end
  end

  // Next-state and next-output logic of the dispatch sequencer
  always_comb begin
    state_s = state_r;
    ptr_s   = ptr_r;
    ctrl_s  = ctrl_r;
    rem_s   = rem_r;
    pend_s  = pend_r;
    ovf_s   = ovf_r;
    start_s = '0;
    insn_s  = insn_r;
    vect_s  = vect_r;
    r0_s    = r0_r;
    busy_s  = busy_r;
    done_s  = done_r;
    err_s   = err_r;
    case (state_r)
      ST_IDLE: begin
        if (run) begin
          ptr_s   = '0;
          ovf_s   = 1'b0;
          busy_s  = 1'b1;
          done_s  = 1'b0;
          err_s   = 1'b0;
          state_s = ST_FETCH;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_FETCH: begin
        // ovf_r means the previous consumption was the last frame of a linear memory
        if (ovf_r) begin
          err_s   = 1'b1;
          state_s = ST_DONE;
        end else begin
          ctrl_s  = rd_s[CTRL_W-1:0];
          ptr_s   = ptr_r + PTR_W'(1);
          ovf_s   = at_end_s;
          state_s = ST_EVAL;
        end
      end
      ST_EVAL: begin
        if (fence_s == FENCE_END) begin
          state_s = ST_DONE;
        end else if ((fence_s == FENCE_ACQ || pend_r) ? (&ready) : ((act_s & ~ready) == '0)) begin
          vect_s = r0v_s;
          for (int i = 0; i < NUM_CORES; i++) begin
            if (r0v_s[i]) begin
              r0_s[i*REG_W +: REG_W] = r0val_s[i*REG_W +: REG_W];
            end else begin
              r0_s[i*REG_W +: REG_W] = r0_r[i*REG_W +: REG_W];
            end
          end
          pend_s  = (fence_s == FENCE_REL);
          rem_s   = n_s;
          state_s = (n_s == '0) ? ST_FETCH : ST_ISSUE;
        end else begin
          state_s = ST_EVAL;
        end
      end
      ST_ISSUE: begin
        if (ovf_r) begin
          err_s   = 1'b1;
          state_s = ST_DONE;
        end else if ((act_s & ~ready) == '0) begin
          insn_s  = rd_s;
          start_s = act_s;
          ptr_s   = ptr_r + PTR_W'(1);
          ovf_s   = at_end_s;
          rem_s   = rem_r - IF_NUM_W'(1);
          state_s = ST_GUARD;
        end else begin
          state_s = ST_ISSUE;
        end
      end
      ST_GUARD: begin
        // ready is not looked at here: cores may still be reacting to the strobe
        state_s = (rem_r == '0) ? ST_FETCH : ST_ISSUE;
      end
      ST_DONE: begin
        busy_s  = 1'b0;
        done_s  = 1'b1;
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Sequencer state and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      ptr_r   <= '0;
      ctrl_r  <= '0;
      rem_r   <= '0;
      pend_r  <= 1'b0;
      ovf_r   <= 1'b0;
      start_r <= '0;
      insn_r  <= '0;
      vect_r  <= '0;
      r0_r    <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      ptr_r   <= ptr_s;
      ctrl_r  <= ctrl_s;
      rem_r   <= rem_s;
      pend_r  <= pend_s;
      ovf_r   <= ovf_s;
      start_r <= start_s;
      insn_r  <= insn_s;
      vect_r  <= vect_s;
      r0_r    <= r0_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
      err_r   <= err_s;
    end
  end

  assign start        = start_r;
  assign insn_data    = insn_r;
  assign init_r0_vect = vect_r;
  assign init_r0      = r0_r;
  assign busy         = busy_r;
  assign done         = done_r;
  assign err          = err_r;

endmodule

// File: doc/task_dispatcher.md
# task_dispatcher

Parametrised task dispatcher between the task-memory loader and the core array. Holds a task program of control frames, each followed by instruction frames. Broadcasts each task to its active core set under NO/ACQ/REL fence rules and initialises per-core R0. Generalises the fixed-size scheduler with parametric core count, depth and widths, a write-port loader, a run/done handshake, an END frame and error reporting.

## Interface
- NUM_CORES, 4, cores driven (1..16)
- TM_DEPTH, 64, task-memory frames (power of two)
- REG_W, 8, R0 width per core
- IF_NUM_W, 4, instruction-frame count width
- FRAME_W, 64, frame width; must be ≥ 2+2·NUM_CORES+IF_NUM_W+NUM_CORES·REG_W, else elaboration error
- clk, in, 1, clock
- reset, in, 1, synchronous, active-high
- tm_we / tm_waddr / tm_wdata, in, 1 / log2(TM_DEPTH) / FRAME_W, memory write port; ignored while busy
- run, in, 1, start program at frame 0; sampled only in IDLE
- ready, in, NUM_CORES, core idle
- start, out, NUM_CORES, one-cycle frame strobe per core
- insn_data, out, FRAME_W, registered frame, valid while start≠0
- init_r0_vect, out, NUM_CORES, cores whose R0 is loaded
- init_r0, out, NUM_CORES·REG_W, R0 values, core i at [i·REG_W +: REG_W]
- busy / done / err, out, 1 each, status

## Operation
- Control frame, LSB first: fence[1:0] (00 NO, 01 ACQ, 10 REL, 11 END), act[NUM_CORES], n[IF_NUM_W], r0v[NUM_CORES], r0 values[NUM_CORES·REG_W]. The next n frames are instruction frames.
- FSM states: IDLE, FETCH, EVAL, ISSUE, GUARD, DONE.
- IDLE. On run: ptr←0, busy←1, done←0, err←0, go to FETCH.
- FETCH. Read the frame at ptr and latch it as the control frame. ptr+1. Go to EVAL.
- EVAL with END: go to DONE.
- EVAL with another fence: dispatch when the condition holds, otherwise stall in EVAL.
  - Condition is all(ready) if fence==ACQ or a REL is pending.
  - Otherwise the condition is (act & ~ready)==0.
- On dispatch:
  - init_r0_vect←r0v.
  - init_r0←r0 values (only lanes with r0v=1 are updated).
  - REL sets the pending flag. Any dispatch by a non-REL task clears it.
  - If n==0, go to FETCH. Otherwise go to ISSUE.
- ISSUE:
  - insn_data←frame[ptr], start←act for one cycle.
  - ptr+1, remaining frame count −1.
  - Go to GUARD.
- GUARD. Lasts one cycle. ready is ignored in this cycle.
  - If the remaining count is 0, go to FETCH.
  - Otherwise wait until (act & ~ready)==0, then go to ISSUE.
- DONE. Set busy←0, done←1, go to IDLE. done holds until the next run or reset.
- Pointer overflow: consuming frame TM_DEPTH−1 when a further frame is needed. Behaviour is set by the Configuration macro.
- act==0 with n>0: frames are consumed and no start is asserted.

## Timing
- Reset values:
  - start, insn_data, init_r0_vect, init_r0, busy, done, err all 0.
  - ptr=0, state IDLE.
  - REL pending flag cleared.
  - Memory contents are not reset.
- Reset mid-program: abort on the next edge. No further start pulses. Memory contents are retained.
- Latency with cores idle:
  - run sampled at edge t.
  - First start is high in cycle t+3.
  - Back-to-back instruction frames to idle cores: one start every 2 cycles.
  - Control frame to control frame with n=0: 2 cycles.
- Write port: one frame per cycle, write-first. A write while busy is dropped.
- run held high in DONE/IDLE restarts on the next edge after done.
- ready changing in the same cycle as start has no effect (GUARD rule).

## Configuration
- TS_WRAP_EN defined:
  - Memory is a ring and ptr wraps TM_DEPTH−1→0.
  - The program ends only on an END frame.
- TS_WRAP_EN undefined:
  - On overflow, err←1 and go to DONE with done←1.
  - No start is issued for the overflowing frame.

## Test plan
- Four cores idle, program {NO, act=0011, n=2, r0v=0011, r0={5,7}}, END.
  - Required: init_r0_vect=0011 and R0 lanes 5,7.
  - start=0011 at t+3 and t+5, with insn_data equal to frames 1 and 2.
  - done=1, err=0.
- Task A uses act=0001 (core0 held busy). Task B is NO with act=0010.
  - Required: B dispatches while core0 is not ready.
  - Variant: B as ACQ. B must stall until ready=1111, then dispatch within 1 cycle.
- Task A is REL, with ready=1110 after A's start. Task B is NO.
  - Required: B stalls until all cores are ready.
- Program without END that fills TM_DEPTH.
  - Macro undefined: err=1, done=1, no extra start.
  - Macro defined: ptr wraps to 0 and frame 0 re-dispatches.
- Edge cases:
  - Assert reset mid-ISSUE: all outputs 0 next cycle, and a subsequent run replays the retained memory.
  - tm_we while busy: memory unchanged.
